// File: rtl/cordic_phase_sequencer.sv
// Phase sequencer feeding an 8-bit CORDIC sine core.
// A prescaled NCO phase accumulator is folded into a first-quadrant angle
// (0..90 degrees). The angle is handed to the core over a start/done handshake.
// The returned y is sign-corrected by quadrant to give a full-wave signed sample.
module cordic_phase_sequencer #(
    parameter int PHASE_W  = 16,
    parameter int PRESCALE = 256,
    parameter int X0       = 77,
    parameter int TIMEOUT  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               phase_clr,
    output logic               cordic_start,
    output logic [7:0]         cordic_angle,
    output logic [7:0]         cordic_x0,
    input  logic               cordic_done,
    input  logic signed [7:0]  cordic_y,
    output logic signed [7:0]  sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               timeout_err,
    output logic               overrun
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_APPLY
    } state_t;

    state_t               state_reg, state_next;
    logic [PS_W-1:0]      ps_cnt_reg;
    logic [PHASE_W-1:0]   phase_reg;
    logic [TO_W-1:0]      wait_cnt_reg;
    logic [7:0]           angle_reg;
    logic                 neg_reg;
    logic signed [7:0]    sample_reg;
    logic                 timeout_reg;
    logic                 overrun_reg;

    logic                 tick;
    logic [1:0]           fold_quad;
    logic [7:0]           fold_frac;
    logic [7:0]           fold_a;
    logic [7:0]           fold_angle;
    logic signed [7:0]    y_clamped;
    logic signed [7:0]    sample_new;

    // A clear in the same cycle swallows the tick so the restart is clean.
    assign tick = en && (ps_cnt_reg == PS_LAST) && !phase_clr;

    // Fold: top two phase bits select the quadrant; the next eight bits scale to 0..89 degrees.
    assign fold_quad  = phase_reg[PHASE_W-1 -: 2];
    assign fold_frac  = phase_reg[PHASE_W-3 -: 8];
    assign fold_a     = 8'(({8'd0, fold_frac} * 16'd90) >> 8);
    assign fold_angle = fold_quad[0] ? (8'd90 - fold_a) : fold_a;

    // Negative y is treated as zero so the output never reaches -128.
    assign y_clamped  = cordic_y[7] ? 8'sd0 : cordic_y;
    assign sample_new = neg_reg ? -y_clamped : y_clamped;

    assign cordic_x0    = 8'(X0);
    assign cordic_angle = angle_reg;
    assign sample       = sample_reg;
    assign timeout_err  = timeout_reg;
    assign overrun      = overrun_reg;

    // Sample-rate prescaler: free-runs while enabled and holds its count when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_reg <= '0;
        end else if (phase_clr) begin
            ps_cnt_reg <= '0;
        end else if (en) begin
            ps_cnt_reg <= (ps_cnt_reg == PS_LAST) ? '0 : ps_cnt_reg + 1'b1;
        end
    end

    // NCO accumulator advances on every tick, even when that tick cannot be serviced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (phase_clr) begin
            phase_reg <= '0;
        end else if (tick) begin
            phase_reg <= phase_reg + freq_word;
        end
    end

    // Capture the folded pre-increment phase when an idle tick starts a conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_reg <= '0;
            neg_reg   <= 1'b0;
        end else if (tick && (state_reg == ST_IDLE)) begin
            angle_reg <= fold_angle;
            neg_reg   <= fold_quad[1];
        end
    end

    // Cycle count in WAIT, used to bound how long the core may take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // Load the sample when entering APPLY, so the new value appears together with sample_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg <= '0;
        end else if ((state_reg == ST_WAIT) && cordic_done) begin
            sample_reg <= sample_new;
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_WAIT) && !cordic_done && (wait_cnt_reg == TO_LAST)) begin
                timeout_reg <= 1'b1;
            end
            if (tick && (state_reg != ST_IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and handshake outputs. cordic_done is only considered in WAIT.
    always_comb begin
        state_next   = state_reg;
        cordic_start = 1'b0;
        busy         = 1'b0;
        sample_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cordic_start = 1'b1;
                busy         = 1'b1;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cordic_done) begin
                    state_next = ST_APPLY;
                end else if (wait_cnt_reg == TO_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_APPLY: begin
                busy         = 1'b1;
                sample_valid = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
